// File: rtl/clock_pkg.sv
// Shared types and field widths for the digital clock alarm path.
package clock_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRing   = 2'd1,
    StSnooze = 2'd2
  } alarm_state_e;

endpackage

// File: rtl/sec_countdown.sv
// Seconds down-counter: clear beats load beats tick; never decrements below zero.
module sec_countdown #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm path sequencer: time-match trigger, ring/snooze/dismiss FSM, 1 Hz buzzer pattern.
module alarm_sequencer
  import clock_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick_1hz,
  input  logic [HOUR_W-1:0]               cur_hour,
  input  logic [MIN_W-1:0]                cur_min,
  input  logic [SEC_W-1:0]                cur_sec,
  input  logic [HOUR_W-1:0]               alm_hour,
  input  logic [MIN_W-1:0]                alm_min,
  input  logic                            alarm_en,
  input  logic                            alarm_set_mode,
  input  logic                            B0,
  input  logic                            B1,
  output logic                            buzzer,
  output logic                            ringing,
  output logic                            snoozed,
  output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_left
);

  localparam int unsigned SlW   = $clog2(MAX_SNOOZE + 1);
  localparam int unsigned RingW = $clog2(RING_SEC + 1);
  localparam int unsigned SnzW  = $clog2(SNOOZE_MIN * 60 + 1);

  localparam logic [RingW-1:0] RingLoad = RingW'(RING_SEC);
  localparam logic [SnzW-1:0]  SnzLoad  = SnzW'(SNOOZE_MIN * 60);
  localparam logic [SlW-1:0]   SlInit   = SlW'(MAX_SNOOZE);

  alarm_state_e     state_q, state_d;
  logic             buzzer_q, buzzer_d;
  logic [SlW-1:0]   snooze_left_q, snooze_left_d;
  logic             match, match_q, trigger;

  logic             ring_clear, ring_load, ring_tick, ring_zero;
  logic             snz_clear, snz_load, snz_tick, snz_zero;
  logic [RingW-1:0] ring_count;
  logic [SnzW-1:0]  snz_count;

  assign match = alarm_en & ~alarm_set_mode & (cur_hour == alm_hour) & (cur_min == alm_min) &
                 (cur_sec == '0);
  assign trigger = match & ~match_q;

  sec_countdown #(
    .W (RingW)
  ) u_ring_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (ring_clear),
    .load       (ring_load),
    .load_value (RingLoad),
    .tick       (ring_tick),
    .count      (ring_count),
    .zero       (ring_zero)
  );

  sec_countdown #(
    .W (SnzW)
  ) u_snooze_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (snz_clear),
    .load       (snz_load),
    .load_value (SnzLoad),
    .tick       (snz_tick),
    .count      (snz_count),
    .zero       (snz_zero)
  );

  always_comb begin
    state_d       = state_q;
    buzzer_d      = buzzer_q;
    snooze_left_d = snooze_left_q;
    ring_clear    = 1'b0;
    ring_load     = 1'b0;
    ring_tick     = 1'b0;
    snz_clear     = 1'b0;
    snz_load      = 1'b0;
    snz_tick      = 1'b0;

    if (!alarm_en) begin
      state_d    = StIdle;
      buzzer_d   = 1'b0;
      ring_clear = 1'b1;
      snz_clear  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            state_d       = StRing;
            buzzer_d      = 1'b1;
            ring_load     = 1'b1;
            snooze_left_d = SlInit;
          end
        end
        StRing: begin
          // Any button press consumes the cycle, so a coincident tick is dropped.
          if (B1) begin
            state_d    = StIdle;
            buzzer_d   = 1'b0;
            ring_clear = 1'b1;
          end else if (B0) begin
            if (snooze_left_q != '0) begin
              state_d       = StSnooze;
              buzzer_d      = 1'b0;
              snooze_left_d = snooze_left_q - SlW'(1);
              ring_clear    = 1'b1;
              snz_load      = 1'b1;
            end
          end else if (tick_1hz && !ring_zero) begin
            if (ring_count == RingW'(1)) begin
              state_d    = StIdle;
              buzzer_d   = 1'b0;
              ring_clear = 1'b1;
            end else begin
              ring_tick = 1'b1;
              buzzer_d  = ~buzzer_q;
            end
          end
        end
        StSnooze: begin
          if (B1) begin
            state_d   = StIdle;
            snz_clear = 1'b1;
          end else if (B0) begin
            state_d = StSnooze;
          end else if (tick_1hz && !snz_zero) begin
            if (snz_count == SnzW'(1)) begin
              state_d   = StRing;
              buzzer_d  = 1'b1;
              snz_clear = 1'b1;
              ring_load = 1'b1;
            end else begin
              snz_tick = 1'b1;
            end
          end
        end
        default: begin
          state_d    = StIdle;
          buzzer_d   = 1'b0;
          ring_clear = 1'b1;
          snz_clear  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      buzzer_q      <= 1'b0;
      snooze_left_q <= SlInit;
      match_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      buzzer_q      <= buzzer_d;
      snooze_left_q <= snooze_left_d;
      match_q       <= match;
    end
  end

  assign buzzer      = buzzer_q;
  assign ringing     = (state_q == StRing);
  assign snoozed     = (state_q == StSnooze);
  assign snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with default parameters (5 min snooze, 60 s ring, 3 snoozes).
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [4:0] cur_hour, alm_hour;
  logic [5:0] cur_min, cur_sec, alm_min;
  logic       alarm_en, alarm_set_mode, B0, B1;
  logic       buzzer, ringing, snoozed;
  logic [1:0] snooze_left;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alarm_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .tick_1hz       (tick_1hz),
    .cur_hour       (cur_hour),
    .cur_min        (cur_min),
    .cur_sec        (cur_sec),
    .alm_hour       (alm_hour),
    .alm_min        (alm_min),
    .alarm_en       (alarm_en),
    .alarm_set_mode (alarm_set_mode),
    .B0             (B0),
    .B1             (B1),
    .buzzer         (buzzer),
    .ringing        (ringing),
    .snoozed        (snoozed),
    .snooze_left    (snooze_left)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      step(1);
      tick_1hz = 1'b0;
      step(1);
    end
  endtask

  task automatic press(input logic b0, input logic b1);
    B0 = b0;
    B1 = b1;
    step(1);
    B0 = 1'b0;
    B1 = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present 07:30:00 for one edge, then move to 07:30:01 so the match falls again.
  task automatic hit_alarm_time();
    cur_sec = 6'd0;
    step(1);
    cur_sec = 6'd1;
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; B0 = 1'b0; B1 = 1'b0;
    alarm_en = 1'b1; alarm_set_mode = 1'b0;
    alm_hour = 5'd7; alm_min = 6'd30;
    cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
    step(2);
    reset = 1'b0;
    check("reset_ringing", {31'd0, ringing}, 32'd0);
    check("reset_snoozed", {31'd0, snoozed}, 32'd0);
    check("reset_buzzer", {31'd0, buzzer}, 32'd0);
    check("reset_snooze_left", {30'd0, snooze_left}, 32'd3);

    // Trigger and unattended ring
    cur_min = 6'd30;
    hit_alarm_time();
    check("trig_ringing", {31'd0, ringing}, 32'd1);
    check("trig_buzzer", {31'd0, buzzer}, 32'd1);
    ticks(1);
    check("tick1_buzzer", {31'd0, buzzer}, 32'd0);
    ticks(1);
    check("tick2_buzzer", {31'd0, buzzer}, 32'd1);
    ticks(57);
    check("tick59_ringing", {31'd0, ringing}, 32'd1);
    check("tick59_buzzer", {31'd0, buzzer}, 32'd0);
    ticks(1);
    check("timeout_ringing", {31'd0, ringing}, 32'd0);
    check("timeout_buzzer", {31'd0, buzzer}, 32'd0);

    // Snooze, re-ring, dismiss
    hit_alarm_time();
    check("trig2_ringing", {31'd0, ringing}, 32'd1);
    press(1'b1, 1'b0);
    check("snz_snoozed", {31'd0, snoozed}, 32'd1);
    check("snz_buzzer", {31'd0, buzzer}, 32'd0);
    check("snz_left", {30'd0, snooze_left}, 32'd2);
    ticks(299);
    check("snz299_snoozed", {31'd0, snoozed}, 32'd1);
    ticks(1);
    check("snz300_ringing", {31'd0, ringing}, 32'd1);
    check("snz300_buzzer", {31'd0, buzzer}, 32'd1);
    press(1'b0, 1'b1);
    check("dismiss_ringing", {31'd0, ringing}, 32'd0);
    check("dismiss_snoozed", {31'd0, snoozed}, 32'd0);

    // Exhaust snoozes; B0 in SNOOZE is ignored
    hit_alarm_time();
    check("trig3_left", {30'd0, snooze_left}, 32'd3);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("b0_in_snooze_snoozed", {31'd0, snoozed}, 32'd1);
    check("b0_in_snooze_left", {30'd0, snooze_left}, 32'd2);
    ticks(300);
    press(1'b1, 1'b0);
    ticks(300);
    press(1'b1, 1'b0);
    check("third_snz_left", {30'd0, snooze_left}, 32'd0);
    ticks(300);
    check("after_third_ringing", {31'd0, ringing}, 32'd1);
    press(1'b1, 1'b0);
    check("fourth_b0_ringing", {31'd0, ringing}, 32'd1);
    check("fourth_b0_left", {30'd0, snooze_left}, 32'd0);
    press(1'b1, 1'b1);
    check("b0b1_ringing", {31'd0, ringing}, 32'd0);
    check("b0b1_snoozed", {31'd0, snoozed}, 32'd0);

    // Trigger suppression
    alarm_set_mode = 1'b1;
    cur_sec = 6'd0;
    step(3);
    check("setmode_no_ring", {31'd0, ringing}, 32'd0);
    cur_sec = 6'd1;
    step(1);
    alarm_set_mode = 1'b0;
    alarm_en = 1'b0;
    cur_sec = 6'd0;
    step(3);
    check("en0_no_ring", {31'd0, ringing}, 32'd0);
    cur_sec = 6'd1;
    step(1);
    alarm_en = 1'b1;
    step(1);

    // alarm_en dropped mid-SNOOZE
    hit_alarm_time();
    press(1'b1, 1'b0);
    check("pre_drop_snoozed", {31'd0, snoozed}, 32'd1);
    alarm_en = 1'b0;
    step(1);
    check("drop_en_snoozed", {31'd0, snoozed}, 32'd0);
    check("drop_en_ringing", {31'd0, ringing}, 32'd0);
    alarm_en = 1'b1;
    step(1);

    // alarm_set_mode does not stop a ring; then reset mid-RING
    hit_alarm_time();
    alarm_set_mode = 1'b1;
    step(2);
    check("setmode_keeps_ring", {31'd0, ringing}, 32'd1);
    alarm_set_mode = 1'b0;
    press(1'b1, 1'b0);
    ticks(300);
    check("pre_reset_ringing", {31'd0, ringing}, 32'd1);
    check("pre_reset_left", {30'd0, snooze_left}, 32'd2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midring_reset_ringing", {31'd0, ringing}, 32'd0);
    check("midring_reset_buzzer", {31'd0, buzzer}, 32'd0);
    check("midring_reset_left", {30'd0, snooze_left}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
